// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB bus signals between requester (master) and completer (slave)
interface apb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input pready, prdata, pslverr);
  modport slave (input psel, penable, pwrite, paddr, pwdata, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer backed by a DEPTH-entry register file.
// Define APB_WAIT_STATE_EN to insert WAIT_CYCLES wait states per transfer.
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic                pclk,
  input logic                presetn,
  apb_slave_regfile_if.slave apb
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef APB_WAIT_STATE_EN
  localparam bit WS_EN = 1'b1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`else
  localparam bit WS_EN = 1'b0;
`endif
  localparam int W = WS_EN ? WAIT_CYCLES : 0;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  setup_err;
`ifdef APB_WAIT_STATE_EN
  logic [CW-1:0]         cnt_q, cnt_d;
`endif
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    regs_d    = regs_q;
`ifdef APB_WAIT_STATE_EN
    cnt_d     = cnt_q;
`endif
    setup_err = 32'(apb.paddr) >= DEPTH;
    if (state_q == IDLE) begin
      // penable without a preceding SETUP is a protocol error and falls through here
      if (apb.psel && !apb.penable) begin
        state_d = ACCESS;
        addr_d  = apb.paddr[AW-1:0];
        write_d = apb.pwrite;
        wdata_d = apb.pwdata;
        err_d   = setup_err;
`ifdef APB_WAIT_STATE_EN
        cnt_d   = CW'(W);
`endif
        if (W == 0) begin
          pready_d  = 1'b1;
          pslverr_d = setup_err;
          if (!apb.pwrite) prdata_d = setup_err ? '0 : regs_q[apb.paddr[AW-1:0]];
        end
      end
    end else if (!apb.psel) begin
      state_d   = IDLE;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
`ifdef APB_WAIT_STATE_EN
      cnt_d     = '0;
`endif
    end else if (pready_q) begin
      if (apb.penable) begin
        if (write_q && !err_q) regs_d[addr_q] = wdata_q;
        state_d   = IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
    end
`ifdef APB_WAIT_STATE_EN
    else if (cnt_q == CW'(1)) begin
      cnt_d     = '0;
      pready_d  = 1'b1;
      pslverr_d = err_q;
      if (!write_q) prdata_d = err_q ? '0 : regs_q[addr_q];
    end else if (cnt_q > CW'(1)) begin
      cnt_d = cnt_q - CW'(1);
    end
`endif
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      regs_q    <= '{default: '0};
`ifdef APB_WAIT_STATE_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
`ifdef APB_WAIT_STATE_EN
      cnt_q     <= cnt_d;
`endif
    end
  end
endmodule
